alu_result_stage: RTL and testbench

- Downstream stage of the 32-bit combinational ALU: captures ALU result, carry-out and the op select that produced them.
- Derives N/Z/C/V condition flags, buffers up to DEPTH results in a valid/ready FIFO, and presents them to writeback.
- Also keeps sticky (OR-accumulated) flags and a retired-op counter for status/debug reads.

---
 rtl/alu_result_stage.sv | 128 ++++++++++++
 tb/tb_alu_result_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Purpose: buffers ALU results with derived N/Z/C/V flags for writeback; keeps sticky flags and a retired-op count.
// Latency: an entry pushed at edge N is visible at the head after edge N; earliest pop is edge N+1 (no bypass).
// Backpressure: in_ready = (count < DEPTH) and never depends on out_ready; a full stage ignores in_valid.
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_cout,
  input  logic [2:0]       in_select,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]      mem_result [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  logic [3:0]       mem_flags  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic       push;
  logic       pop;
  logic       is_sub;
  logic       is_logic;
  logic       is_add;
  logic [3:0] new_flags;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = mem_result[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];

  // Decode op class from the select and derive {N,Z,C,V}; the ALU carry is only an add carry.
  always_comb begin
    is_sub    = 1'b0;
    is_logic  = 1'b0;
    is_add    = 1'b0;
    new_flags = 4'b0000;
    is_sub    = (in_select == 3'b011);
    is_logic  = (in_select == 3'b001) || (in_select == 3'b010) || (in_select == 3'b100);
    is_add    = !is_sub && !is_logic;
    new_flags[3] = in_result[31];
    new_flags[2] = (in_result == 32'h0);
    new_flags[1] = is_add & in_cout;
    if (is_add)
      new_flags[0] = (in_a_msb == in_b_msb) && (in_result[31] != in_a_msb);
    else if (is_sub)
      new_flags[0] = (in_a_msb != in_b_msb) && (in_result[31] != in_a_msb);
    else
      new_flags[0] = 1'b0;
  end

  // Entry storage: written at the tail on push; cleared on reset so the idle head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_tag[i]    <= '0;
        mem_flags[i]  <= '0;
      end
    end else if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_tag[wr_ptr]    <= in_tag;
      mem_flags[wr_ptr]  <= new_flags;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy holds on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags accumulate popped flags; a clear alongside a pop keeps only that pop's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 4'b0000;
    end else if (pop) begin
      sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | out_flags;
    end else if (sticky_clr) begin
      sticky_flags <= 4'b0000;
    end
  end

  // Retired-op counter: one per pop, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag derivation, ordering, backpressure, counters and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants and a tiny op-count model.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_cout;
  logic [2:0]  in_select;
  logic        in_a_msb;
  logic        in_b_msb;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;
  logic [15:0] op_count;

  int total;
  int bad;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_sticky;

  alu_result_stage #(.DEPTH(2), .TAG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_cout(in_cout),
    .in_select(in_select), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_flags(out_flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] r, input logic co, input logic [2:0] s,
                     input logic a, input logic b, input logic [4:0] t);
    in_valid  = v;
    in_result = r;
    in_cout   = co;
    in_select = s;
    in_a_msb  = a;
    in_b_msb  = b;
    in_tag    = t;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Flag vectors: result, cout, select, a_msb, b_msb, expected {N,Z,C,V}
  logic [31:0] v_res [6] = '{32'h80000000, 32'h00000000, 32'h80000001, 32'h00000005, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic        v_co  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0]  v_sel [6] = '{3'b000, 3'b000, 3'b011, 3'b110, 3'b100, 3'b011};
  logic        v_a   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        v_b   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0]  v_fl  [6] = '{4'b1001, 4'b0111, 4'b1001, 4'b0010, 4'b1000, 4'b0001};

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 16'd0;
    exp_sticky = 4'b0000;
    rst_n = 1'b0;
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0);

    // Reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_op_count", {16'b0, op_count}, 32'd0);
    chk("rst_sticky", {28'b0, sticky_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

    // Zero result from a logic op -> Z only
    drv(1'b1, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("z_out_valid", {31'b0, out_valid}, 32'd1);
    chk("z_flags", {28'b0, out_flags}, 32'b0100);
    chk("z_tag", {27'b0, out_tag}, 32'd1);
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    exp_sticky = 4'b0100;
    chk("z_op_count", {16'b0, op_count}, {16'b0, exp_cnt});
    chk("z_sticky", {28'b0, sticky_flags}, {28'b0, exp_sticky});
    chk("z_empty", {31'b0, out_valid}, 32'd0);
    // Pop request on empty stage changes nothing
    tick();
    out_ready = 1'b0;
    chk("empty_pop_cnt", {16'b0, op_count}, {16'b0, exp_cnt});

    // Flag table: push, inspect head, pop
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, v_res[i], v_co[i], v_sel[i], v_a[i], v_b[i], 5'(i + 2));
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_flags", i), {28'b0, out_flags}, {28'b0, v_fl[i]});
      chk($sformatf("vec%0d_result", i), out_result, v_res[i]);
      chk($sformatf("vec%0d_tag", i), {27'b0, out_tag}, 32'(i + 2));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt++;
      exp_sticky = exp_sticky | v_fl[i];
      chk($sformatf("vec%0d_sticky", i), {28'b0, sticky_flags}, {28'b0, exp_sticky});
      chk($sformatf("vec%0d_cnt", i), {16'b0, op_count}, {16'b0, exp_cnt});
    end

    // Clear without a pop
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("clr_alone", {28'b0, sticky_flags}, 32'd0);
    chk("clr_alone_cnt", {16'b0, op_count}, {16'b0, exp_cnt});

    // Fill to DEPTH with out_ready low; third push must be held
    drv(1'b1, 32'h10, 1'b0, 3'b001, 1'b0, 1'b0, 5'd10);
    tick();
    chk("fill1_in_ready", {31'b0, in_ready}, 32'd1);
    drv(1'b1, 32'h11, 1'b0, 3'b001, 1'b0, 1'b0, 5'd11);
    tick();
    chk("fill2_in_ready", {31'b0, in_ready}, 32'd0);
    drv(1'b1, 32'h12, 1'b0, 3'b001, 1'b0, 1'b0, 5'd12);
    tick();
    chk("held_in_ready", {31'b0, in_ready}, 32'd0);
    chk("held_head_tag", {27'b0, out_tag}, 32'd10);
    chk("held_head_res", out_result, 32'h10);
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("drain1_tag", {27'b0, out_tag}, 32'd11);
    chk("drain1_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    chk("drain2_tag", {27'b0, out_tag}, 32'd12);
    chk("drain2_res", out_result, 32'h12);
    tick();
    exp_cnt++;
    out_ready = 1'b0;
    chk("drain3_empty", {31'b0, out_valid}, 32'd0);
    chk("drain3_cnt", {16'b0, op_count}, {16'b0, exp_cnt});

    // Streaming push+pop at count=1 for 10 cycles
    drv(1'b1, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0, 5'd20);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0, 5'(21 + i));
      out_ready = 1'b1;
      tick();
      exp_cnt++;
      chk($sformatf("stream%0d_tag", i), {27'b0, out_tag}, 32'(21 + i));
      chk($sformatf("stream%0d_rdy", i), {30'b0, out_valid, in_ready}, 32'b11);
    end
    chk("stream_cnt", {16'b0, op_count}, {16'b0, exp_cnt});

    // Run the counter up to all-ones while streaming zero-result entries
    begin
      int n;
      n = 32'hFFFF - int'(exp_cnt);
      for (int i = 0; i < n; i++) begin
        tick();
        exp_cnt++;
      end
    end
    chk("cnt_allones", {16'b0, op_count}, 32'h0000FFFF);
    // Push a carry-only entry while popping -> counter wraps
    drv(1'b1, 32'h5, 1'b1, 3'b000, 1'b0, 1'b0, 5'd7);
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    chk("cnt_wrap", {16'b0, op_count}, 32'd0);
    chk("wrap_head_flags", {28'b0, out_flags}, 32'b0010);
    chk("pre_clr_sticky", {28'b0, sticky_flags}, 32'b0100);
    // Clear together with the pop of the 0010 entry
    sticky_clr = 1'b1;
    tick();
    exp_cnt++;
    sticky_clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_pop_sticky", {28'b0, sticky_flags}, 32'b0010);
    chk("clr_pop_cnt", {16'b0, op_count}, {16'b0, exp_cnt});

    // Reset with two entries buffered
    drv(1'b1, 32'hA5A5A5A5, 1'b0, 3'b010, 1'b0, 1'b0, 5'd3);
    tick();
    tick();
    in_valid = 1'b0;
    chk("prerst_valid", {31'b0, out_valid}, 32'd1);
    chk("prerst_full", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_cnt", {16'b0, op_count}, 32'd0);
    chk("midrst_sticky", {28'b0, sticky_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", {31'b0, out_valid}, 32'd0);
    chk("postrst_ready", {31'b0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
